// File: rtl/vga_scan_800x600.sv
// vga_scan_800x600: 800x600@72 scan generator with clamped lookahead coordinates
// and a registered RGB444 pixel composed from two overlay layers. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module vga_scan_800x600 #(
  parameter int   H_VIS    = 800,
  parameter int   H_FP     = 56,
  parameter int   H_SYNC   = 120,
  parameter int   H_BP     = 64,
  parameter int   V_VIS    = 600,
  parameter int   V_FP     = 37,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 23,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        score_fill,
  input  logic        field_fill,
  input  logic [11:0] score_color,
  input  logic [11:0] field_color,
  input  logic [11:0] bg_color,
  output logic [11:0] x_p,
  output logic [11:0] y_p,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        pix_en,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST   = 12'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_VIS_W  = 12'(H_VIS);
  localparam logic [11:0] V_VIS_W  = 12'(V_VIS);
  localparam logic [11:0] X_MAX    = 12'(H_VIS - 1);
  localparam logic [11:0] Y_MAX    = 12'(V_VIS - 1);
  localparam logic [11:0] HS_FIRST = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_VIS + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_VIS + V_FP + V_SYNC - 1);

  logic [11:0] hcount;
  logic [11:0] vcount;
  logic [11:0] h_next;
  logic [11:0] v_next;
  logic        h_vis_next;
  logic        v_vis_next;
  logic [11:0] rgb_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        advance;

  // Counters move on the edge that raises pix_en, so the first edge after
  // reset lands on (0,0).
  assign advance = ~pix_en;

  always_comb begin
    h_next = (hcount == H_LAST) ? 12'd0 : hcount + 12'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      v_next = (vcount == V_LAST) ? 12'd0 : vcount + 12'd1;
    end
    h_vis_next = (h_next < H_VIS_W);
    v_vis_next = (v_next < V_VIS_W);
    rgb_next   = 12'h000;
    if (h_vis_next && v_vis_next) begin
      if (score_fill)      rgb_next = score_color;
      else if (field_fill) rgb_next = field_color;
      else                 rgb_next = bg_color;
    end
    hsync_next = (h_next >= HS_FIRST && h_next <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_next = (v_next >= VS_FIRST && v_next <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en      <= 1'b0;
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      x_p         <= X_MAX;
      y_p         <= Y_MAX;
      rgb         <= 12'h000;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= 1'b0;
      if (advance) begin
        hcount      <= h_next;
        vcount      <= v_next;
        x_p         <= h_vis_next ? h_next : X_MAX;
        y_p         <= v_vis_next ? v_next : Y_MAX;
        rgb         <= rgb_next;
        hsync       <= hsync_next;
        vsync       <= vsync_next;
        frame_start <= (h_next == 12'd0) && (v_next == 12'd0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_800x600.sv
// tb_vga_scan_800x600: directed checks of scan timing, clamping and colour select.
// Vertical timing is shortened to keep the run short; horizontal timing is the real one.
`default_nettype none
`timescale 1ns/1ps

module tb_vga_scan_800x600;

  localparam int TV_VIS  = 11;
  localparam int TV_FP   = 1;
  localparam int TV_SYNC = 2;
  localparam int TV_BP   = 1;
  localparam int HT      = 1040;
  localparam int VT      = TV_VIS + TV_FP + TV_SYNC + TV_BP;   // 15 lines
  localparam int Y_CLAMP = TV_VIS - 1;

  localparam logic [11:0] SC = 12'hF00;
  localparam logic [11:0] FC = 12'h0F0;
  localparam logic [11:0] BC = 12'h00F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        score_fill = 1'b0;
  logic        field_fill = 1'b0;
  logic [11:0] score_color = SC;
  logic [11:0] field_color = FC;
  logic [11:0] bg_color = BC;
  logic [11:0] x_p;
  logic [11:0] y_p;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        pix_en;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  vga_scan_800x600 #(
    .V_VIS (TV_VIS),
    .V_FP  (TV_FP),
    .V_SYNC(TV_SYNC),
    .V_BP  (TV_BP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .score_fill (score_fill),
    .field_fill (field_fill),
    .score_color(score_color),
    .field_color(field_color),
    .bg_color   (bg_color),
    .x_p        (x_p),
    .y_p        (y_p),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .pix_en     (pix_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          h;
    int          v;
    logic        sf;
    logic        ff;
    logic [11:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int h, input int v, input logic sf, input logic ff,
                     input logic [11:0] c, input int x, input int y,
                     input logic hs, input logic vs);
    vec_t e;
    e.h = h; e.v = v; e.sf = sf; e.ff = ff; e.rgb = c;
    e.x = 12'(x); e.y = 12'(y); e.hs = hs; e.vs = vs;
    vecs.push_back(e);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int n;
    int hs_cnt;
    int hs_first;
    int x799_cnt;
    int line2_k;
    int vs_cnt;
    int vs_first;
    int fs_cnt;
    int fs_k;
    logic [11:0] prev_x;

    //   h     v   sf ff  rgb     x    y        hs vs
    add(5,     2,  0, 0, BC,     5,   2,       0, 0);
    add(799,   2,  0, 1, FC,     799, 2,       0, 0);
    add(800,   2,  1, 1, 12'h0,  799, 2,       0, 0);
    add(856,   2,  1, 0, 12'h0,  799, 2,       1, 0);
    add(975,   2,  0, 0, 12'h0,  799, 2,       1, 0);
    add(976,   2,  1, 1, 12'h0,  799, 2,       0, 0);
    add(1039,  5,  1, 1, 12'h0,  799, 5,       0, 0);
    add(10,   10,  1, 1, SC,     10,  10,      0, 0);
    add(11,   10,  0, 1, FC,     11,  10,      0, 0);
    add(12,   10,  0, 0, BC,     12,  10,      0, 0);
    add(900,  10,  1, 1, 12'h0,  799, 10,      1, 0);
    add(0,    11,  1, 1, 12'h0,  0,   Y_CLAMP, 0, 0);
    add(0,    12,  0, 0, 12'h0,  0,   Y_CLAMP, 0, 1);
    add(1039, 13,  0, 0, 12'h0,  799, Y_CLAMP, 0, 1);
    add(0,    14,  0, 0, 12'h0,  0,   Y_CLAMP, 0, 0);
    add(1039, 14,  1, 1, 12'h0,  799, Y_CLAMP, 0, 0);

    // Reset held for 3 clks
    repeat (3) tick();
    check("reset x_p", x_p, 799);
    check("reset y_p", y_p, Y_CLAMP);
    check("reset rgb", rgb, 0);
    check("reset hsync", hsync, 0);
    check("reset vsync", vsync, 0);
    check("reset pix_en", pix_en, 0);
    check("reset frame_start", frame_start, 0);

    reset = 1'b0;
    tick();
    check("release frame_start", frame_start, 1);
    check("release pix_en", pix_en, 1);
    check("release x_p", x_p, 0);
    check("release y_p", y_p, 0);
    tick();
    check("release+1 frame_start", frame_start, 0);
    check("release+1 pix_en", pix_en, 0);
    check("release+1 x_p hold", x_p, 0);

    // Two lines of horizontal timing; k counts clks since (0,0) was loaded
    hs_cnt = 0; hs_first = -1; x799_cnt = 0; line2_k = -1; prev_x = x_p;
    for (int k = 2; k <= 2 * 2 * HT; k++) begin
      tick();
      if (hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
      if (x_p == 12'd799 && y_p == 12'd0) x799_cnt++;
      if (x_p == 12'd0 && prev_x != 12'd0 && line2_k < 0) line2_k = k;
      prev_x = x_p;
    end
    check("hsync first clk", hs_first, 1712);
    check("hsync clks in 2 lines", hs_cnt, 480);
    // 799 itself (2 clks) plus clamped hcount 800..1039 (480 clks)
    check("x_p at 799 clks line0", x799_cnt, 482);
    check("line period", line2_k, 2080);
    check("line2 start y_p", y_p, 2);

    // Table of pixel vectors, in scan order
    cur = 2 * HT;
    foreach (vecs[i]) begin
      n = vecs[i].v * HT + vecs[i].h;
      repeat (2 * (n - cur) - 1) tick();
      score_fill = vecs[i].sf;
      field_fill = vecs[i].ff;
      tick();
      cur = n;
      check($sformatf("vec%0d rgb", i), rgb, vecs[i].rgb);
      check($sformatf("vec%0d x_p", i), x_p, vecs[i].x);
      check($sformatf("vec%0d y_p", i), y_p, vecs[i].y);
      check($sformatf("vec%0d hsync", i), hsync, vecs[i].hs);
      check($sformatf("vec%0d vsync", i), vsync, vecs[i].vs);
    end
    score_fill = 1'b0;
    field_fill = 1'b0;

    // Wrap from the last pixel of the frame to (0,0)
    tick();
    check("wrap-1 frame_start", frame_start, 0);
    check("wrap-1 x_p", x_p, 799);
    tick();
    check("wrap frame_start", frame_start, 1);
    check("wrap x_p", x_p, 0);
    check("wrap y_p", y_p, 0);

    // One full frame
    vs_cnt = 0; vs_first = -1; fs_cnt = 0; fs_k = -1;
    for (int k = 1; k <= 2 * HT * VT; k++) begin
      tick();
      if (vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = k;
      end
      if (frame_start) begin
        fs_cnt++;
        fs_k = k;
      end
    end
    check("vsync first clk", vs_first, 2 * HT * (TV_VIS + TV_FP));
    check("vsync clks", vs_cnt, 2 * HT * TV_SYNC);
    check("frame_start count", fs_cnt, 1);
    check("frame period", fs_k, 2 * HT * VT);

    // Mid-frame reset at (400,3)
    repeat (2 * (3 * HT + 400)) tick();
    check("pre-reset x_p", x_p, 400);
    check("pre-reset y_p", y_p, 3);
    reset = 1'b1;
    tick();
    check("midreset x_p", x_p, 799);
    check("midreset y_p", y_p, Y_CLAMP);
    check("midreset rgb", rgb, 0);
    check("midreset pix_en", pix_en, 0);
    check("midreset frame_start", frame_start, 0);
    reset = 1'b0;
    tick();
    check("post-reset frame_start", frame_start, 1);
    check("post-reset x_p", x_p, 0);
    check("post-reset y_p", y_p, 0);
    check("post-reset pix_en", pix_en, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
